// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, load formatting and load-wait stall.
// Optional load timeout force-retire is enabled by defining WB_LOAD_TIMEOUT_EN.
//
// state  | meaning
// S_RUN  | no load waiting, or a load got its data in its first WB cycle
// S_WAIT | load held in WB, stalling upstream until dmem_rvalid (or timeout)
module mem_wb_stage #(
    parameter int REGISTER_WIDTH      = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int LOAD_TIMEOUT_CYCLES = 16
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst,
    input  logic                           mem_valid,
    input  logic                           mem_reg_write,
    input  logic [REGISTER_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [1:0]                     mem_wb_sel,
    input  logic [2:0]                     mem_funct3,
    input  logic [REGISTER_WIDTH-1:0]      mem_alu_result,
    input  logic [REGISTER_WIDTH-1:0]      mem_pc_plus4,
    input  logic                           dmem_rvalid,
    input  logic [REGISTER_WIDTH-1:0]      dmem_rdata,
    output logic                           wb_stall,
    output logic                           wb_valid,
    output logic                           we,
    output logic [REGISTER_ADDR_WIDTH-1:0] wd_addr,
    output logic [REGISTER_WIDTH-1:0]      wd_data,
    output logic                           wb_load_timeout
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          wait_cnt;
    logic                      wb_reg_write;
    logic [1:0]                wb_sel;
    logic [2:0]                wb_funct3;
    logic [REGISTER_WIDTH-1:0] wb_alu_result;
    logic [REGISTER_WIDTH-1:0] wb_pc_plus4;

    logic                      is_load;
    logic                      timeout_fire;
    logic                      load_done;
    logic [7:0]                byte_val;
    logic [15:0]               half_val;
    logic [REGISTER_WIDTH-1:0] load_data;
    logic [REGISTER_WIDTH-1:0] sel_data;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LOAD_TIMEOUT_CYCLES);
    logic timeout_q;

    assign timeout_fire    = (state == S_WAIT) && (wait_cnt == TIMEOUT_CNT) && !dmem_rvalid;
    assign wb_load_timeout = timeout_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            timeout_q <= 1'b0;
        else if (timeout_fire)
            timeout_q <= 1'b1;
    end
`else
    assign timeout_fire    = 1'b0;
    assign wb_load_timeout = 1'b0;
`endif

    // Stall is a function of WB state and dmem only, never of mem_* inputs.
    assign is_load   = wb_valid && (wb_sel == 2'b01);
    assign load_done = dmem_rvalid || timeout_fire;
    assign wb_stall  = is_load && !load_done;
    assign we        = wb_valid && wb_reg_write && (wd_addr != '0) && (!is_load || load_done);

    assign byte_val = dmem_rdata[{wb_alu_result[1:0], 3'b000} +: 8];
    assign half_val = wb_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        case (wb_funct3)
            3'b000:  load_data = {{(REGISTER_WIDTH-8){byte_val[7]}}, byte_val};
            3'b100:  load_data = {{(REGISTER_WIDTH-8){1'b0}}, byte_val};
            3'b001:  load_data = {{(REGISTER_WIDTH-16){half_val[15]}}, half_val};
            3'b101:  load_data = {{(REGISTER_WIDTH-16){1'b0}}, half_val};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        sel_data = wb_alu_result;
        case (wb_sel)
            2'b01:   sel_data = load_data;
            2'b10:   sel_data = wb_pc_plus4;
            default: sel_data = wb_alu_result;
        endcase
    end

    // Zero when not writing keeps the ID-stage bypass clean; a timed-out load writes 0.
    assign wd_data = (we && !timeout_fire) ? sel_data : '0;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state         <= S_RUN;
            wait_cnt      <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wd_addr       <= '0;
            wb_sel        <= 2'b00;
            wb_funct3     <= 3'b000;
            wb_alu_result <= '0;
            wb_pc_plus4   <= '0;
        end else begin
            if (!wb_stall) begin
                wb_valid      <= mem_valid;
                wb_reg_write  <= mem_reg_write;
                wd_addr       <= mem_rd_addr;
                wb_sel        <= mem_wb_sel;
                wb_funct3     <= mem_funct3;
                wb_alu_result <= mem_alu_result;
                wb_pc_plus4   <= mem_pc_plus4;
            end
            case (state)
                S_RUN: begin
                    if (is_load && !dmem_rvalid) begin
                        state    <= S_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid || timeout_fire) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
